// File: rtl/ptw_mem_responder.sv
// ptw_mem_responder
// Serves the MMU page-table-walk port. A PTE read request (ptw_req/ptw_addr)
// is turned into a single Wishbone classic read; the returned word is handed
// back on ptw_data together with a one-cycle ptw_ack. Bus errors, timeouts
// and misaligned addresses come back as an all-zero PTE (V=0) plus a
// one-cycle bus_fault pulse, so the MMU faults through its normal path.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ptw_req, ptw_addr   walk request and PTE physical address (held until acked)
//   ptw_data, ptw_ack   returned PTE (zero unless acked) and one-cycle strobe
//   flush               SFENCE.VMA / satp write, invalidates the PTE cache
//   wb_*                Wishbone classic read master (we=0, sel=4'hF)
//   bus_fault           pulse when a read ended by error, timeout or misalignment
//   busy                high whenever the responder is not idle
//
// Parameters:
//   TIMEOUT_CYCLES      bus cycles to wait for ack/err, 0 waits forever
//   PTE_CACHE_ENTRIES   entries of the optional PTE cache (power of 2)
//
// Build option:
//   PTW_PTE_CACHE_EN    when defined, adds a small fully associative PTE cache
//                       that answers repeated walks without a bus read.
module ptw_mem_responder #(
   parameter int TIMEOUT_CYCLES    = 64,
   parameter int PTE_CACHE_ENTRIES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ptw_req,
   input  logic [31:0] ptw_addr,
   output logic [31:0] ptw_data,
   output logic        ptw_ack,
   input  logic        flush,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_adr_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   output logic        bus_fault,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] timeoutCnt_q, timeoutCnt_d;
   logic        ackEn_q, ackEn_d;
   logic        busFault_q, busFault_d;
   logic        fillOk_q, fillOk_d;

   logic        cacheHit;
   logic [31:0] cacheData;

   // Every output is a register or a decode of the state register, so the
   // request inputs never reach the bus combinationally.
   assign wb_cyc_o  = (state_q == BUS);
   assign wb_stb_o  = (state_q == BUS);
   assign wb_we_o   = 1'b0;
   assign wb_sel_o  = 4'hF;
   assign wb_adr_o  = adr_q;
   assign ptw_ack   = (state_q == RESP) && ackEn_q;
   assign ptw_data  = ptw_ack ? data_q : 32'h0;
   assign bus_fault = busFault_q;
   assign busy      = (state_q != IDLE);

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         adr_q        <= '0;
         data_q       <= '0;
         timeoutCnt_q <= '0;
         ackEn_q      <= 1'b0;
         busFault_q   <= 1'b0;
         fillOk_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         adr_q        <= adr_d;
         data_q       <= data_d;
         timeoutCnt_q <= timeoutCnt_d;
         ackEn_q      <= ackEn_d;
         busFault_q   <= busFault_d;
         fillOk_q     <= fillOk_d;
      end
   end

   // Next-state logic. ackEn tracks whether the MMU kept its request up for
   // the whole walk; a withdrawn request still finishes the bus read but is
   // neither acknowledged nor cached. fillOk marks a read that may be cached:
   // it is cleared by any flush seen while the read is in flight.
   always_comb begin
      state_d      = state_q;
      adr_d        = adr_q;
      data_d       = data_q;
      timeoutCnt_d = timeoutCnt_q;
      ackEn_d      = ackEn_q;
      busFault_d   = 1'b0;
      fillOk_d     = fillOk_q;
      unique case (state_q)
         IDLE: begin
            if (ptw_req) begin
               adr_d        = {ptw_addr[31:2], 2'b00};
               ackEn_d      = 1'b1;
               timeoutCnt_d = '0;
               fillOk_d     = 1'b0;
               if (ptw_addr[1:0] != 2'b00) begin
                  data_d     = '0;
                  busFault_d = 1'b1;
                  state_d    = RESP;
               end else if (cacheHit) begin
                  data_d  = cacheData;
                  state_d = RESP;
               end else begin
                  fillOk_d = 1'b1;
                  state_d  = BUS;
               end
            end
         end
         BUS: begin
            timeoutCnt_d = timeoutCnt_q + 32'd1;
            if (!ptw_req) begin
               ackEn_d = 1'b0;
            end
            if (flush) begin
               fillOk_d = 1'b0;
            end
            if (wb_ack_i) begin
               data_d   = wb_dat_i;
               fillOk_d = fillOk_q && !flush && wb_dat_i[0];
               state_d  = RESP;
            end else if (wb_err_i) begin
               data_d     = '0;
               fillOk_d   = 1'b0;
               busFault_d = 1'b1;
               state_d    = RESP;
            end else if ((TIMEOUT_CYCLES != 0) &&
                         (timeoutCnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
               data_d     = '0;
               fillOk_d   = 1'b0;
               busFault_d = 1'b1;
               state_d    = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef PTW_PTE_CACHE_EN
   localparam int IDX_W = (PTE_CACHE_ENTRIES > 1) ? $clog2(PTE_CACHE_ENTRIES) : 1;

   logic [PTE_CACHE_ENTRIES-1:0] cValid_q;
   logic [29:0]                  cTag_q [PTE_CACHE_ENTRIES];
   logic [31:0]                  cPte_q [PTE_CACHE_ENTRIES];
   logic [IDX_W-1:0]             rrPtr_q;
   logic [IDX_W-1:0]             victim;
   logic                         cacheFill;

   // Tag lookup against the live request address. A flush in the same cycle
   // forces a miss so a stale entry can never answer.
   always_comb begin
      cacheHit  = 1'b0;
      cacheData = '0;
      for (int i = 0; i < PTE_CACHE_ENTRIES; i++) begin
         if (cValid_q[i] && (cTag_q[i] == ptw_addr[31:2])) begin
            cacheHit  = 1'b1;
            cacheData = cPte_q[i];
         end
      end
      if (flush) begin
         cacheHit = 1'b0;
      end
   end

   // Victim is the lowest free entry; only when the cache is full does the
   // round-robin pointer pick one.
   always_comb begin
      victim = rrPtr_q;
      for (int i = PTE_CACHE_ENTRIES - 1; i >= 0; i--) begin
         if (!cValid_q[i]) begin
            victim = IDX_W'(i);
         end
      end
   end

   assign cacheFill = (state_q == RESP) && ackEn_q && fillOk_q && !flush;

   // Valid bits and replacement pointer; flush takes priority over a fill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cValid_q <= '0;
         rrPtr_q  <= '0;
      end else if (flush) begin
         cValid_q <= '0;
      end else if (cacheFill) begin
         cValid_q[victim] <= 1'b1;
         if (&cValid_q) begin
            rrPtr_q <= (rrPtr_q == IDX_W'(PTE_CACHE_ENTRIES - 1)) ? '0 : rrPtr_q + 1'b1;
         end
      end
   end

   // Tag and PTE storage need no reset; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (cacheFill) begin
         cTag_q[victim] <= adr_q[31:2];
         cPte_q[victim] <= data_q;
      end
   end
`else
   logic unusedCacheCfg;

   assign cacheHit       = 1'b0;
   assign cacheData      = '0;
   assign unusedCacheCfg = ^{flush, fillOk_q, PTE_CACHE_ENTRIES};
`endif

endmodule

// File: tb/tb_ptw_mem_responder.sv
// tb_ptw_mem_responder
// Drives walk requests against ptw_mem_responder with a behavioural Wishbone
// slave, and checks every walk against a transaction-level reference model
// (latency, data, fault pulse, bus cycle count, latched address, and the
// PTE cache contents when PTW_PTE_CACHE_EN is defined).
module tb_ptw_mem_responder;

   localparam int TB_TIMEOUT = 4;
   localparam int K_ACK      = 0;
   localparam int K_ERR      = 1;
   localparam int K_BOTH     = 2;
   localparam int K_SILENT   = 3;

`ifdef PTW_PTE_CACHE_EN
   localparam bit CACHE_ON = 1'b1;
`else
   localparam bit CACHE_ON = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        ptw_req;
   logic [31:0] ptw_addr;
   logic [31:0] ptw_data;
   logic        ptw_ack;
   logic        flush;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic        bus_fault;
   logic        busy;

   int vecCount  = 0;
   int missCount = 0;

   bit          mValid [4];
   logic [31:0] mAddr  [4];
   logic [31:0] mPte   [4];
   int          mRr = 0;

   ptw_mem_responder #(
      .TIMEOUT_CYCLES   (TB_TIMEOUT),
      .PTE_CACHE_ENTRIES(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ptw_req  (ptw_req),
      .ptw_addr (ptw_addr),
      .ptw_data (ptw_data),
      .ptw_ack  (ptw_ack),
      .flush    (flush),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_we_o  (wb_we_o),
      .wb_sel_o (wb_sel_o),
      .wb_adr_o (wb_adr_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack_i (wb_ack_i),
      .wb_err_i (wb_err_i),
      .bus_fault(bus_fault),
      .busy     (busy)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts a comparison and reports it when the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecCount++;
      if (got !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Random walk address from a small pool so that repeats occur, with an
   // occasional misaligned offset.
   function automatic logic [31:0] pickAddr();
      logic [31:0] a;
      a = 32'h8010_0000 + 32'($urandom_range(0, 5)) * 32'h40;
      if ($urandom_range(0, 9) == 0) begin
         a[1:0] = 2'($urandom_range(1, 3));
      end
      return a;
   endfunction

   // One complete walk: optional pre-flush, request, slave behaviour of the
   // given kind after 'waits' wait states, then checks against the model.
   // With 'chain' the request stays high through the ack with nextAddr.
   task automatic applyStimulus(input logic [31:0] addr, input int kind, input int waits,
                                input logic [31:0] rdata, input bit withdraw,
                                input bit flushMid, input bit preFlush,
                                input bit chain, input logic [31:0] nextAddr);
      bit          mis, hit, wd, fm, expFault, okRead, leak, bad;
      logic [31:0] expAdr, expData, adrSeen, ackData;
      int          lat, busExp, ackAt, ackCnt, faultAt, faultCnt, busCnt, victim;
      hit = 1'b0; leak = 1'b0; bad = 1'b0; expFault = 1'b0;
      expData = '0; adrSeen = '0; ackData = '0;
      lat = 1; busExp = 0; ackAt = 0; ackCnt = 0; faultAt = 0; faultCnt = 0; busCnt = 0;
      if (preFlush) begin
         @(negedge clk);
         flush = 1'b1;
         if (CACHE_ON) begin
            for (int i = 0; i < 4; i++) mValid[i] = 1'b0;
         end
         @(negedge clk);
         flush = 1'b0;
      end else begin
         @(negedge clk);
      end
      checkOutput("idleGap", {29'd0, ptw_ack, wb_cyc_o, busy}, 32'd0);

      mis    = (addr[1:0] != 2'b00);
      expAdr = {addr[31:2], 2'b00};
      okRead = (kind == K_ACK) || (kind == K_BOTH);
      if (CACHE_ON && !mis) begin
         for (int i = 0; i < 4; i++) begin
            if (mValid[i] && mAddr[i] == expAdr) begin
               hit     = 1'b1;
               expData = mPte[i];
            end
         end
      end
      if (mis) begin
         expFault = 1'b1;
         expData  = '0;
      end else if (!hit) begin
         busExp   = (kind == K_SILENT) ? TB_TIMEOUT : waits + 1;
         lat      = busExp + 1;
         expFault = !okRead;
         expData  = okRead ? rdata : 32'h0;
      end
      wd = withdraw && (busExp > 0);
      fm = flushMid && (busExp > 0);

      ptw_req  = 1'b1;
      ptw_addr = addr;
      for (int n = 1; n <= lat; n++) begin
         @(negedge clk);
         if (n == 1) adrSeen = wb_adr_o;
         if (ptw_ack) begin
            ackCnt++;
            if (ackAt == 0) begin
               ackAt   = n;
               ackData = ptw_data;
            end
         end else if (ptw_data != 32'h0) begin
            leak = 1'b1;
         end
         if (bus_fault) begin
            faultCnt++;
            if (faultAt == 0) faultAt = n;
         end
         if (wb_cyc_o) begin
            busCnt++;
            if (!wb_stb_o || wb_adr_o != expAdr) bad = 1'b1;
         end
         flush    = fm && (n == 1);
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
         wb_dat_i = $urandom();
         if (wb_cyc_o && (busCnt - 1) == waits) begin
            case (kind)
               K_ACK:  begin wb_ack_i = 1'b1; wb_dat_i = rdata; end
               K_ERR:  begin wb_err_i = 1'b1; end
               K_BOTH: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = rdata; end
               default: begin end
            endcase
         end
         if (wd && n == 1) ptw_req = 1'b0;
         if (n == lat) begin
            if (chain && !wd) begin
               ptw_addr = nextAddr;
            end else begin
               ptw_req  = 1'b0;
               ptw_addr = $urandom();
            end
         end
      end
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      flush    = 1'b0;

      checkOutput("ackAt",     32'(ackAt),    wd ? 32'd0 : 32'(lat));
      checkOutput("ackCnt",    32'(ackCnt),   wd ? 32'd0 : 32'd1);
      checkOutput("ackData",   ackData,       wd ? 32'd0 : expData);
      checkOutput("faultAt",   32'(faultAt),  expFault ? 32'(lat) : 32'd0);
      checkOutput("faultCnt",  32'(faultCnt), expFault ? 32'd1 : 32'd0);
      checkOutput("busCycles", 32'(busCnt),   32'(busExp));
      checkOutput("adrLatch",  adrSeen,       expAdr);
      checkOutput("busAdrStb", 32'(bad),      32'd0);
      checkOutput("dataLeak",  32'(leak),     32'd0);

      if (CACHE_ON) begin
         if (fm) begin
            for (int i = 0; i < 4; i++) mValid[i] = 1'b0;
         end
         if (busExp > 0 && okRead && rdata[0] && !wd && !fm) begin
            victim = -1;
            for (int i = 0; i < 4; i++) begin
               if (!mValid[i] && victim < 0) victim = i;
            end
            if (victim < 0) begin
               victim = mRr;
               mRr    = (mRr + 1) % 4;
            end
            mValid[victim] = 1'b1;
            mAddr[victim]  = expAdr;
            mPte[victim]   = rdata;
         end
      end
   endtask

   // Reset checks, directed walks from the plan, then a randomized run.
   initial begin
      logic [31:0] a;
      logic [31:0] nextA;
      bit          prevChain;
      bit          wdr, fmr, pfr, chr;
      rst      = 1'b1;
      ptw_req  = 1'b0;
      ptw_addr = '0;
      flush    = 1'b0;
      wb_dat_i = '0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mValid[i] = 1'b0;
         mAddr[i]  = '0;
         mPte[i]   = '0;
      end
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstCtl",  {26'd0, ptw_ack, wb_cyc_o, wb_stb_o, wb_we_o, bus_fault, busy}, 32'd0);
      checkOutput("rstSel",  {28'd0, wb_sel_o}, 32'h0000_000F);
      checkOutput("rstAdr",  wb_adr_o, 32'd0);
      checkOutput("rstData", ptw_data, 32'd0);
      rst = 1'b0;

      applyStimulus(32'h8040_0008, K_ACK,    0, 32'h2000_0401, 0, 0, 0, 0, 32'h0);
      applyStimulus(32'h8040_0010, K_BOTH,   3, 32'h0000_00CF, 0, 0, 0, 0, 32'h0);
      applyStimulus(32'h8040_0020, K_ERR,    0, 32'h1234_5671, 0, 0, 0, 0, 32'h0);
      applyStimulus(32'h8040_0030, K_SILENT, 0, 32'h0,         0, 0, 0, 0, 32'h0);
      applyStimulus(32'h8040_0022, K_ACK,    0, 32'h5555_0001, 0, 0, 0, 0, 32'h0);
      applyStimulus(32'h8000_1000, K_ACK,    0, 32'h0000_1001, 0, 0, 0, 1, 32'h8000_2004);
      applyStimulus(32'h8000_2004, K_ACK,    1, 32'h0000_2003, 0, 0, 0, 0, 32'h0);
      applyStimulus(32'h8040_0008, K_ACK,    0, 32'hDEAD_0001, 0, 0, 0, 0, 32'h0);
      applyStimulus(32'h8040_0008, K_ACK,    0, 32'hBEEF_0001, 0, 0, 1, 0, 32'h0);
      applyStimulus(32'h8040_0040, K_ACK,    2, 32'h0BAD_0001, 1, 0, 0, 0, 32'h0);
      applyStimulus(32'h8050_0000, K_ACK,    0, 32'hA000_0001, 0, 0, 1, 0, 32'h0);
      applyStimulus(32'h8050_0004, K_ACK,    0, 32'hA000_0011, 0, 0, 0, 0, 32'h0);
      applyStimulus(32'h8050_0008, K_ACK,    0, 32'hA000_0021, 0, 0, 0, 0, 32'h0);
      applyStimulus(32'h8050_000C, K_ACK,    0, 32'hA000_0031, 0, 0, 0, 0, 32'h0);
      applyStimulus(32'h8050_0010, K_ACK,    0, 32'hA000_0041, 0, 0, 0, 0, 32'h0);
      applyStimulus(32'h8050_0000, K_ACK,    0, 32'hC000_0001, 0, 0, 0, 0, 32'h0);
      applyStimulus(32'h8050_0008, K_ACK,    0, 32'hC000_0021, 0, 0, 0, 0, 32'h0);

      prevChain = 1'b0;
      nextA     = pickAddr();
      for (int w = 0; w < 60; w++) begin
         int kind;
         int waits;
         a     = nextA;
         nextA = pickAddr();
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: kind = K_ACK;
            5, 6:          kind = K_ERR;
            7, 8:          kind = K_BOTH;
            default:       kind = K_SILENT;
         endcase
         waits = $urandom_range(0, 3);
         wdr   = ($urandom_range(0, 9) == 0);
         fmr   = ($urandom_range(0, 9) == 0);
         pfr   = !prevChain && ($urandom_range(0, 9) == 0);
         chr   = !wdr && ($urandom_range(0, 2) == 0);
         applyStimulus(a, kind, waits, $urandom(), wdr, fmr, pfr, chr, nextA);
         prevChain = chr;
      end

      @(negedge clk);
      checkOutput("endIdle",  {29'd0, ptw_ack, wb_cyc_o, busy}, 32'd0);
      checkOutput("constant", {27'd0, wb_we_o, wb_sel_o}, 32'h0000_000F);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/ptw_mem_responder.md
Name: ptw_mem_responder

Overview:
- Serves the MMU page-table-walk port: accepts ptw_req/ptw_addr, fetches the 32-bit PTE over a Wishbone classic master read, and returns it on ptw_data with a single-cycle ptw_ack.
- Sits between the MMU and the memory arbiter.
- Converts bus errors and timeouts into an invalid PTE (V=0), so the MMU raises a page fault through its normal path.

Parameters:
- TIMEOUT_CYCLES, 64: maximum BUS-state cycles to wait for wb_ack_i/wb_err_i; 0 disables the timeout.
- PTE_CACHE_ENTRIES, 4: entries in the optional PTE cache (power of 2, ≥1). Unused without the macro.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ptw_req  in  1  PTW request; held high with stable ptw_addr until acked
- ptw_addr  in  32  PTE physical address, word aligned
- ptw_data  out  32  returned PTE, valid only while ptw_ack=1
- ptw_ack  out  1  one-cycle response strobe
- flush  in  1  SFENCE.VMA / satp write; invalidates the PTE cache
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  constant 0
- wb_sel_o  out  4  constant 4'hF
- wb_adr_o  out  32  {ptw_addr[31:2],2'b00}, latched
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  bus acknowledge
- wb_err_i  in  1  bus error
- bus_fault  out  1  one-cycle pulse when a walk read ended by error or timeout
- busy  out  1  state != IDLE

Behaviour:
- Reset: async; state=IDLE. All outputs 0 except wb_sel_o=4'hF. Timeout counter 0. Cache invalid.
- All outputs are registered or decoded from state only; no combinational path from ptw_req to the bus.
- IDLE:
  - ptw_req=1 → latch address into wb_adr_o. Cache hit (macro on) → RESP. Otherwise → BUS.
  - ptw_req=0 → stay in IDLE.
- BUS:
  - cyc=stb=1 every cycle in this state; wb_adr_o held constant.
  - wb_ack_i=1 → data_reg=wb_dat_i, → RESP.
  - Otherwise wb_err_i=1 → data_reg=32'h0, bus_fault pulse, → RESP.
  - ack and err in the same cycle → ack wins.
  - Neither, and TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1 → drop cyc/stb, data_reg=0, bus_fault pulse, → RESP.
  - Counter clears on BUS entry and increments each BUS cycle.
- RESP:
  - ptw_ack=1, ptw_data=data_reg, for exactly one cycle → IDLE.
  - ptw_req is ignored in this cycle; the MMU may already be presenting its next-level address, which is sampled in the following IDLE cycle.
- Withdrawn request: ptw_req low during BUS → the bus read still completes. On reaching RESP with ptw_req=0, ptw_ack is suppressed and no cache fill occurs.
- Latency, zero-wait slave: req seen at cycle T → cyc/stb at T+1 → ptw_ack at T+2. Each bus wait state adds one cycle. Back-to-back two-level walk minimum is 5 cycles.
- ptw_addr[1:0]≠0 → treated as a bus error: no bus cycle, data 0, bus_fault pulse, RESP at T+1.
- ptw_data is 0 whenever ptw_ack=0.

Optional Feature:
- Macro PTW_PTE_CACHE_EN.
- Defined:
  - Fully associative cache of PTE_CACHE_ENTRIES {valid, addr[31:2], pte}.
  - Hit in IDLE → RESP next cycle (1-cycle latency), no bus activity.
  - Fill on a successful wb_ack_i read with data bit0 (V)=1 that reaches an acked RESP. Errors, timeouts and V=0 PTEs are never cached.
  - Victim choice: first invalid entry, else a round-robin pointer.
  - flush clears all valid bits the same cycle. flush coinciding with a fill → fill dropped.
  - flush during BUS → that read is not filled.
- Undefined: no cache storage. flush ignored. Every request goes to the bus.

Test Plan:
- Zero-wait slave returns 32'h2000_0401 for addr 32'h8040_0008 → wb_adr_o=32'h8040_0008, ptw_ack at T+2, ptw_data=32'h2000_0401, bus_fault=0.
- Slave inserts 3 wait states, then asserts wb_ack_i and wb_err_i together with 32'h0000_00CF → ptw_ack at T+5, ptw_data=32'h0000_00CF, no bus_fault.
- wb_err_i on the first BUS cycle → ptw_data=0, bus_fault pulse, ptw_ack at T+2; cache not filled.
- TIMEOUT_CYCLES=4, slave silent → cyc/stb high for exactly 4 cycles, then ptw_ack with data 0 and bus_fault=1.
- Two-level walk (req held through the ack cycle with a new address) → exactly two bus cycles and two single-cycle acks, second address correct, no duplicate read.
- With PTW_PTE_CACHE_EN:
  - Repeat the same addr → second ack at T+1 with no wb_cyc_o.
  - Assert flush, then repeat → bus read again.
  - Fill 5 distinct addrs with 4 entries → first addr evicted.
